// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared encodings and constants for the memory controller.
//   state_t     : mem_state encodings (IDLE 00, SLB 01, IF 10)
//   IO_BASE_DEF : default start of the memory-mapped IO region
//   SZ_*        : legal access sizes in bytes
package mem_ctrl_pkg;
   typedef enum logic [1:0] {ST_IDLE = 2'b00, ST_SLB = 2'b01, ST_IF = 2'b10} state_t;
   localparam logic [31:0] IO_BASE_DEF = 32'h0003_0000;
   localparam logic [2:0] SZ_BYTE = 3'd1;
   localparam logic [2:0] SZ_HALF = 3'd2;
   localparam logic [2:0] SZ_WORD = 3'd4;
endpackage

// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: requester-side bundle of the memory controller.
//   slb_send/slb_type/slb_addr/slb_store_val/slb_size : load/store request
//   mem_valid/mem_state/mem_load_val                  : load/store completion and status
//   if_send/if_addr                                   : fetch request
//   if_valid/if_inst                                  : fetch completion
// Modports: master = requester side, slave = mem_ctrl.
interface mem_ctrl_if;
   logic        slb_send;
   logic        slb_type;
   logic [31:0] slb_addr;
   logic [31:0] slb_store_val;
   logic [2:0]  slb_size;
   logic        mem_valid;
   logic [1:0]  mem_state;
   logic [31:0] mem_load_val;
   logic        if_send;
   logic [31:0] if_addr;
   logic        if_valid;
   logic [31:0] if_inst;
   modport master (
      output slb_send, slb_type, slb_addr, slb_store_val, slb_size, if_send, if_addr,
      input  mem_valid, mem_state, mem_load_val, if_valid, if_inst
   );
   modport slave (
      input  slb_send, slb_type, slb_addr, slb_store_val, slb_size, if_send, if_addr,
      output mem_valid, mem_state, mem_load_val, if_valid, if_inst
   );
endinterface

// File: rtl/mem_ctrl_byte_seq.sv
// mem_byte_seq: byte counter, address generation and little-endian byte assembly.
//   clk, rst   : clock, synchronous active-high reset
//   rdy        : global enable, low freezes all state
//   start      : load base address, clear counter and assembly register
//   adv        : step to the next byte (also commits the assembled word)
//   addr_in    : base address taken on start
//   mem_din    : RAM read byte, belongs to the address of the previous cycle
//   cnt        : current byte index
//   mem_a      : base + cnt, wraps at 32 bits
//   word       : assembled word including the byte arriving this cycle
module mem_byte_seq
   import mem_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        start,
   input  logic        adv,
   input  logic [31:0] addr_in,
   input  logic [7:0]  mem_din,
   output logic [2:0]  cnt,
   output logic [31:0] mem_a,
   output logic [31:0] word
);
   logic [31:0] base;
   logic [31:0] acc;
   logic [1:0]  lane;
   logic [4:0]  sh;
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt  <= '0;
         base <= '0;
         acc  <= '0;
      end else if (rdy) begin
         if (start) begin
            cnt  <= '0;
            base <= addr_in;
            acc  <= '0;
         end else if (adv) begin
            cnt <= cnt + 3'd1;
            acc <= word;
         end
      end
   end
   assign mem_a = base + 32'(cnt);
   // mem_din at index cnt carries the byte addressed at cnt-1
   assign lane = 2'(cnt - 3'd1);
   assign sh   = {lane, 3'b000};
   assign word = (cnt == '0) ? acc : (acc & ~(32'hFF << sh)) | (32'(mem_din) << sh);
endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial RAM controller arbitrating load/store and fetch requests.
//   clk, rst        : clock, synchronous active-high reset (priority over everything)
//   rdy             : global enable, low freezes all state and outputs
//   jump_rst        : flush; aborts loads/fetches, stores still finish
//   bus (slave)     : request/response bundle, see mem_ctrl_if
//   mem_din         : RAM read byte, valid one cycle after its address
//   mem_dout/mem_a/mem_wr : RAM write byte, address, write strobe
//   io_buffer_full  : IO output buffer full
// Optional feature: define MEM_CTRL_IO_STALL_EN to hold store bytes aimed at
// addresses >= IO_BASE while io_buffer_full is high.
module mem_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter logic [31:0] IO_BASE = IO_BASE_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        jump_rst,
   mem_ctrl_if.slave   bus,
   input  logic [7:0]  mem_din,
   output logic [7:0]  mem_dout,
   output logic [31:0] mem_a,
   output logic        mem_wr,
   input  logic        io_buffer_full
);
   state_t      state, state_nx;
   logic        stype;
   logic [2:0]  size;
   logic [31:0] sval;
   logic        valid_q, fvalid_q;
   logic [31:0] load_q, inst_q;
   logic [2:0]  cnt;
   logic [31:0] word;
   logic        idle_ok, acc_slb, acc_if, ld, ld_done, st_done, stall, adv;
   // no acceptance while a completion pulse is out, so one request never
   // turns into two accesses
   assign idle_ok = state == ST_IDLE && !valid_q && !fvalid_q && !jump_rst;
   assign acc_slb = idle_ok && bus.slb_send;
   assign acc_if  = idle_ok && !bus.slb_send && bus.if_send;
   assign ld      = state == ST_IF || (state == ST_SLB && !stype);
   // a load finishes one cycle after its last address, when the last byte arrives
   assign ld_done = ld && !jump_rst && cnt == size;
   assign st_done = state == ST_SLB && stype && !stall && cnt == size - SZ_BYTE;
   assign adv     = state != ST_IDLE && !stall;
`ifdef MEM_CTRL_IO_STALL_EN
   assign stall = state == ST_SLB && stype && mem_a >= IO_BASE && io_buffer_full;
`else
   logic unused_io;
   assign stall     = 1'b0;
   assign unused_io = io_buffer_full | (|IO_BASE);
`endif
   mem_byte_seq u_seq (
      .clk     (clk),
      .rst     (rst),
      .rdy     (rdy),
      .start   (acc_slb || acc_if),
      .adv     (adv),
      .addr_in (acc_slb ? bus.slb_addr : bus.if_addr),
      .mem_din (mem_din),
      .cnt     (cnt),
      .mem_a   (mem_a),
      .word    (word)
   );
   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else if (rdy) state <= state_nx;
   end
   always_comb begin
      state_nx = state;
      if (state == ST_IDLE) state_nx = acc_slb ? ST_SLB : acc_if ? ST_IF : ST_IDLE;
      else if ((ld && jump_rst) || ld_done || st_done) state_nx = ST_IDLE;
   end
   always_comb begin
      bus.mem_state    = state;
      bus.mem_valid    = valid_q;
      bus.if_valid     = fvalid_q;
      bus.mem_load_val = load_q;
      bus.if_inst      = inst_q;
      mem_wr           = state == ST_SLB && stype && !stall;
      mem_dout         = 8'(sval >> {cnt[1:0], 3'b000});
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         stype    <= 1'b0;
         size     <= '0;
         sval     <= '0;
         valid_q  <= 1'b0;
         fvalid_q <= 1'b0;
         load_q   <= '0;
         inst_q   <= '0;
      end else if (rdy) begin
         if (acc_slb) begin
            stype <= bus.slb_type;
            size  <= bus.slb_size;
            sval  <= bus.slb_store_val;
         end else if (acc_if) begin
            stype <= 1'b0;
            size  <= SZ_WORD;
         end
         valid_q  <= state == ST_SLB && (ld_done || st_done);
         fvalid_q <= state == ST_IF && ld_done;
         if (state == ST_SLB && ld_done) load_q <= word;
         if (state == ST_IF && ld_done) inst_q <= word;
      end
   end
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed vector and sequence bench for mem_ctrl with a byte RAM model.
module tb_mem_ctrl;
   typedef struct {
      logic        is_if;
      logic        typ;
      logic [31:0] addr;
      logic [2:0]  size;
      logic [31:0] val;
      logic [31:0] exp;
      int          lat;
   } vec_t;
   logic        clk = 0, rst, rdy, jump_rst, io_buffer_full, ram_init;
   logic [7:0]  mem_din, mem_dout;
   logic [31:0] mem_a;
   logic        mem_wr;
   logic [7:0]  ram [4096];
   int          nchk = 0, nfail = 0, both_hi = 0;
   vec_t        vecs [11];
   mem_ctrl_if bus ();
   mem_ctrl #(.IO_BASE(32'h0003_0000)) dut (
      .clk            (clk),
      .rst            (rst),
      .rdy            (rdy),
      .jump_rst       (jump_rst),
      .bus            (bus),
      .mem_din        (mem_din),
      .mem_dout       (mem_dout),
      .mem_a          (mem_a),
      .mem_wr         (mem_wr),
      .io_buffer_full (io_buffer_full)
   );
   always #5 clk = ~clk;
   // RAM stalls together with the controller so read data stays aligned
   always @(posedge clk) begin
      if (ram_init) begin
         for (int i = 0; i < 4096; i++) ram[i] <= 8'h00;
         ram[12'h100] <= 8'h11; ram[12'h101] <= 8'h22;
         ram[12'h102] <= 8'h33; ram[12'h103] <= 8'h44;
         ram[12'hFFE] <= 8'hA1; ram[12'hFFF] <= 8'hB2;
         ram[12'h000] <= 8'hC3; ram[12'h001] <= 8'hD4;
         mem_din <= 8'h00;
      end else if (rdy) begin
         if (mem_wr) ram[mem_a[11:0]] <= mem_dout;
         mem_din <= ram[mem_a[11:0]];
      end
   end
   always @(negedge clk) if (bus.mem_valid && bus.if_valid) both_hi++;
   function automatic logic [31:0] rd32(input logic [31:0] a);
      return {ram[12'(a + 3)], ram[12'(a + 2)], ram[12'(a + 1)], ram[12'(a)]};
   endfunction
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask
   task automatic do_req(input vec_t v, output int lat, output int wrs, output logic [1:0] st0);
      @(negedge clk);
      bus.slb_type = v.typ; bus.slb_addr = v.addr; bus.slb_size = v.size;
      bus.slb_store_val = v.val; bus.if_addr = v.addr;
      bus.slb_send = !v.is_if; bus.if_send = v.is_if;
      @(posedge clk); #1;
      bus.slb_send = 0; bus.if_send = 0;
      bus.slb_type = ~v.typ; bus.slb_addr = ~v.addr; bus.slb_size = 3'd1;
      bus.slb_store_val = ~v.val; bus.if_addr = ~v.addr;
      lat = -1; wrs = 0; st0 = 2'b11;
      for (int i = 0; i < 20 && lat < 0; i++) begin
         @(negedge clk);
         if (i == 0) st0 = bus.mem_state;
         if (mem_wr) wrs++;
         if (v.is_if ? bus.if_valid : bus.mem_valid) lat = i;
      end
   endtask
   initial begin
      int lat, wrs, vcyc, wcyc, cnt;
      logic [1:0] st0, st_after;
      logic got_ld, got_if, ld_before;
      logic [31:0] inst;
      vecs[0]  = '{0, 0, 32'h100,      3'd4, 32'h0,        32'h44332211, 5};
      vecs[1]  = '{0, 0, 32'h102,      3'd2, 32'h0,        32'h00004433, 3};
      vecs[2]  = '{0, 0, 32'h103,      3'd1, 32'h0,        32'h00000044, 2};
      vecs[3]  = '{0, 1, 32'h200,      3'd2, 32'hAABBCCDD, 32'h0000CCDD, 2};
      vecs[4]  = '{0, 1, 32'h210,      3'd4, 32'h12345678, 32'h12345678, 4};
      vecs[5]  = '{0, 0, 32'h210,      3'd4, 32'h0,        32'h12345678, 5};
      vecs[6]  = '{0, 1, 32'h220,      3'd1, 32'hFFFFFF5A, 32'h0000005A, 1};
      vecs[7]  = '{0, 0, 32'h21F,      3'd2, 32'h0,        32'h00005A00, 3};
      vecs[8]  = '{0, 0, 32'hFFFFFFFE, 3'd4, 32'h0,        32'hD4C3B2A1, 5};
      vecs[9]  = '{1, 0, 32'h100,      3'd4, 32'h0,        32'h44332211, 5};
      vecs[10] = '{1, 0, 32'h210,      3'd4, 32'h0,        32'h12345678, 5};
      rst = 1; rdy = 1; jump_rst = 0; io_buffer_full = 0; ram_init = 1;
      bus.slb_send = 0; bus.slb_type = 0; bus.slb_addr = 0; bus.slb_size = 0;
      bus.slb_store_val = 0; bus.if_send = 0; bus.if_addr = 0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_state", 32'(bus.mem_state), 0);
      check("rst_valid", 32'(bus.mem_valid), 0);
      check("rst_if_valid", 32'(bus.if_valid), 0);
      check("rst_wr", 32'(mem_wr), 0);
      check("rst_a", mem_a, 0);
      check("rst_dout", 32'(mem_dout), 0);
      check("rst_load_val", bus.mem_load_val, 0);
      check("rst_if_inst", bus.if_inst, 0);
      ram_init = 0; rst = 0;
      for (int k = 0; k < 11; k++) begin
         do_req(vecs[k], lat, wrs, st0);
         check($sformatf("v%0d_lat", k), 32'(lat), 32'(vecs[k].lat));
         check($sformatf("v%0d_wrs", k), 32'(wrs), vecs[k].typ ? 32'(vecs[k].size) : 0);
         check($sformatf("v%0d_state", k), 32'(st0), vecs[k].is_if ? 2 : 1);
         check($sformatf("v%0d_data", k),
               vecs[k].is_if ? bus.if_inst : vecs[k].typ ? rd32(vecs[k].addr) : bus.mem_load_val,
               vecs[k].exp);
      end
      // load and fetch requested together: load first, fetch after the load pulse
      @(negedge clk);
      bus.slb_type = 0; bus.slb_addr = 32'h100; bus.slb_size = 3'd1; bus.if_addr = 32'h210;
      bus.slb_send = 1; bus.if_send = 1;
      @(posedge clk); #1;
      @(negedge clk);
      check("both_slb_first", 32'(bus.mem_state), 1);
      got_ld = 0; got_if = 0; ld_before = 0; inst = 0;
      for (int i = 0; i < 30 && !got_if; i++) begin
         if (i > 0) @(negedge clk);
         if (bus.mem_valid) begin got_ld = 1; bus.slb_send = 0; end
         if (bus.if_valid) begin got_if = 1; bus.if_send = 0; ld_before = got_ld; inst = bus.if_inst; end
      end
      bus.slb_send = 0; bus.if_send = 0;
      check("both_if_done", 32'(got_if), 1);
      check("both_ld_before_if", 32'(ld_before), 1);
      check("both_if_inst", inst, 32'h12345678);
      check("both_load_val", bus.mem_load_val, 32'h00000011);
      // flush during a fetch
      @(negedge clk);
      bus.if_addr = 32'h100; bus.if_send = 1;
      @(posedge clk); #1;
      bus.if_send = 0;
      repeat (3) @(negedge clk);
      check("jmp_if_busy", 32'(bus.mem_state), 2);
      jump_rst = 1;
      @(negedge clk);
      check("jmp_if_idle", 32'(bus.mem_state), 0);
      jump_rst = 0;
      cnt = 0;
      repeat (8) begin @(negedge clk); if (bus.if_valid) cnt++; end
      check("jmp_if_no_valid", 32'(cnt), 0);
      // flush during a 4-byte store: store still completes
      @(negedge clk);
      bus.slb_type = 1; bus.slb_addr = 32'h240; bus.slb_size = 3'd4;
      bus.slb_store_val = 32'hCAFEF00D; bus.slb_send = 1;
      @(posedge clk); #1;
      bus.slb_send = 0;
      wrs = 0; vcyc = -1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (mem_wr) wrs++;
         if (bus.mem_valid && vcyc < 0) vcyc = i;
         jump_rst = (i == 1);
      end
      jump_rst = 0;
      check("jmp_st_wrs", 32'(wrs), 4);
      check("jmp_st_valid_cyc", 32'(vcyc), 4);
      check("jmp_st_data", rd32(32'h240), 32'hCAFEF00D);
      // flush in IDLE blocks acceptance for that cycle only
      @(negedge clk);
      bus.slb_type = 0; bus.slb_addr = 32'h100; bus.slb_size = 3'd1;
      bus.slb_send = 1; jump_rst = 1;
      @(posedge clk); #1;
      jump_rst = 0;
      @(negedge clk);
      check("jmp_idle_block", 32'(bus.mem_state), 0);
      @(posedge clk); #1;
      bus.slb_send = 0;
      @(negedge clk);
      check("jmp_idle_accept", 32'(bus.mem_state), 1);
      cnt = 0;
      for (int i = 0; i < 10 && cnt == 0; i++) begin @(negedge clk); if (bus.mem_valid) cnt++; end
      check("jmp_idle_done", 32'(cnt), 1);
      // send held across completion: exactly one access
      @(negedge clk);
      bus.slb_type = 1; bus.slb_addr = 32'h260; bus.slb_size = 3'd2;
      bus.slb_store_val = 32'h0000BEEF; bus.slb_send = 1;
      @(posedge clk); #1;
      wrs = 0; vcyc = -1; st_after = 2'b11;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (mem_wr) wrs++;
         if (vcyc >= 0 && i == vcyc + 1) begin st_after = bus.mem_state; bus.slb_send = 0; end
         if (bus.mem_valid && vcyc < 0) vcyc = i;
      end
      bus.slb_send = 0;
      check("hold_wrs", 32'(wrs), 2);
      check("hold_valid_cyc", 32'(vcyc), 2);
      check("hold_no_reaccept", 32'(st_after), 0);
      check("hold_data", rd32(32'h260), 32'h0000BEEF);
      // rdy low for 3 cycles stretches a load by 3 cycles
      @(negedge clk);
      bus.slb_type = 0; bus.slb_addr = 32'h100; bus.slb_size = 3'd4; bus.slb_send = 1;
      @(posedge clk); #1;
      bus.slb_send = 0;
      lat = -1;
      for (int i = 0; i < 16 && lat < 0; i++) begin
         if (i == 1) rdy = 0;
         if (i == 4) rdy = 1;
         @(negedge clk);
         if (bus.mem_valid) lat = i;
         @(posedge clk); #1;
      end
      rdy = 1;
      check("rdy_lat", 32'(lat), 8);
      check("rdy_data", bus.mem_load_val, 32'h44332211);
      // byte store into IO space with the IO buffer full for 3 cycles
      @(negedge clk);
      bus.slb_type = 1; bus.slb_addr = 32'h0003_0000; bus.slb_size = 3'd1;
      bus.slb_store_val = 32'h77; bus.slb_send = 1; io_buffer_full = 1;
      @(posedge clk); #1;
      bus.slb_send = 0;
      lat = -1; wrs = 0; wcyc = -1;
      for (int i = 0; i < 10; i++) begin
         if (i == 3) io_buffer_full = 0;
         @(negedge clk);
         if (mem_wr) begin wrs++; wcyc = i; end
         if (bus.mem_valid && lat < 0) lat = i;
         @(posedge clk); #1;
      end
      io_buffer_full = 0;
      check("io_wrs", 32'(wrs), 1);
`ifdef MEM_CTRL_IO_STALL_EN
      check("io_wr_cyc", 32'(wcyc), 3);
      check("io_valid_cyc", 32'(lat), 4);
`else
      check("io_wr_cyc", 32'(wcyc), 0);
      check("io_valid_cyc", 32'(lat), 1);
`endif
      check("io_data", 32'(ram[12'h000]), 32'h77);
      // reset in the middle of a store abandons the remaining bytes
      @(negedge clk);
      bus.slb_type = 1; bus.slb_addr = 32'h280; bus.slb_size = 3'd4;
      bus.slb_store_val = 32'h01020304; bus.slb_send = 1;
      @(posedge clk); #1;
      bus.slb_send = 0;
      @(posedge clk); #1;
      rst = 1;
      @(posedge clk); #1;
      rst = 0;
      @(negedge clk);
      check("mid_rst_state", 32'(bus.mem_state), 0);
      check("mid_rst_a", mem_a, 0);
      check("mid_rst_dout", 32'(mem_dout), 0);
      cnt = 0;
      repeat (6) begin @(negedge clk); if (mem_wr || bus.mem_valid) cnt++; end
      check("mid_rst_quiet", 32'(cnt), 0);
      check("mid_rst_data", rd32(32'h280), 32'h00000304);
      check("never_both_valid", 32'(both_hi), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end
endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have parameter IO_BASE, default 32'h0003_0000; addresses >= IO_BASE are memory-mapped IO.
REQ-002 clk  in  1  clock; all state on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 rdy  in  1  global enable; low freezes all state and outputs.
REQ-005 jump_rst  in  1  pipeline flush from mispredict.
REQ-006 slb_send  in  1  load/store request from the load/store buffer.
REQ-007 slb_type  in  1  0 = load, 1 = store.
REQ-008 slb_addr  in  32  byte address.
REQ-009 slb_store_val  in  32  store data, low slb_size bytes used.
REQ-010 slb_size  in  3  byte count: 1, 2 or 4.
REQ-011 mem_valid  out  1  one-cycle completion pulse to the load/store buffer.
REQ-012 mem_state  out  2  00 idle, 01 serving load/store, 10 serving fetch.
REQ-013 mem_load_val  out  32  load result, zero-extended, little-endian.
REQ-014 if_send  in  1  fetch request; if_addr  in  32  fetch address.
REQ-015 if_valid  out  1  one-cycle fetch completion pulse; if_inst  out  32  fetched word.
REQ-016 mem_din  in  8  RAM read byte, valid one cycle after its address.
REQ-017 mem_dout  out  8  RAM write byte; mem_a  out  32  RAM address; mem_wr  out  1  write strobe.
REQ-018 io_buffer_full  in  1  IO output buffer cannot accept a byte.

Function
REQ-019 Accept requests only in IDLE (mem_state 00) and never in a cycle where mem_valid or if_valid is being driven high; load/store request wins over fetch.
REQ-020 Load of N bytes: mem_a = addr+k at busy cycles k=0..N-1; byte k captured from mem_din at cycle k+1 into bits [8k+7:8k]; mem_valid=1, mem_state=00, mem_load_val stable at cycle N+1.
REQ-021 Fetch: identical to 4-byte load, result on if_inst with if_valid pulse; mem_state 10 while busy.
REQ-022 Store of N bytes: mem_wr=1, mem_a=addr+k, mem_dout=slb_store_val[8k+7:8k] at cycles k=0..N-1; mem_valid pulse at cycle N.
REQ-023 Request fields latched at acceptance; later changes on slb_*/if_* inputs are ignored until IDLE.
REQ-024 mem_wr=0 in every cycle not writing a byte; mem_a increments with 32-bit wrap-around.
REQ-025 jump_rst: in-flight load or fetch aborts next cycle to IDLE, no valid pulse; in-flight store completes all bytes and pulses mem_valid.
REQ-026 jump_rst in IDLE blocks acceptance that cycle.
REQ-027 mem_valid and if_valid are never high in the same cycle.

Reset
REQ-028 rst: mem_state=00, mem_valid=0, if_valid=0, mem_wr=0, mem_a=0, mem_dout=0, mem_load_val=0, if_inst=0, byte counter 0; an in-flight store is abandoned.
REQ-029 rst has priority over jump_rst and rdy.

Configuration
REQ-030 MEM_CTRL_IO_STALL_EN defined: a store byte to address >= IO_BASE while io_buffer_full=1 is held (mem_wr=0, counter frozen) until io_buffer_full=0; undefined: io_buffer_full is ignored.

Structure
REQ-031 Shared package holds mem_state encodings (IDLE/SLB/IF), IO_BASE default and size constants.
REQ-032 One natural sub-module: mem_byte_seq (byte counter, address generation, byte assembly), instantiated once.

Verification
REQ-033 Load size 4 at 0x100, RAM bytes 11,22,33,44 -> mem_load_val=32'h44332211, mem_valid high exactly at cycle 5 after acceptance.
REQ-034 Store size 2, addr 0x200, val 32'hAABBCCDD -> writes DD@0x200, CC@0x201, mem_valid at cycle 2, mem_wr low afterwards.
REQ-035 slb_send and if_send together in IDLE -> mem_state=01 first; fetch served after load pulse, if_valid later.
REQ-036 jump_rst at fetch cycle 2 -> IDLE next cycle, no if_valid; jump_rst during 4-byte store -> all 4 bytes written, mem_valid pulsed.
REQ-037 With MEM_CTRL_IO_STALL_EN, SB to 0x30000 with io_buffer_full=1 for 3 cycles -> mem_wr stays 0 for 3 cycles, then 1 write, mem_valid next cycle.
REQ-038 slb_send held high across completion -> exactly one access per request; no acceptance in the mem_valid cycle.
